axi_rd_slave: RTL and testbench
===============================

Name: axi_rd_slave

Overview:
- AXI-style read responder: the memory-side end of the simplified read channel driven by the team's read masters (AR + R, no ID/size/burst type).
- Accepts one read burst at a time on AR and splits it into single-word read requests on the DDR2 controller native read port.
- Buffers returned words in a small FIFO and streams them on R with rvalid/rready backpressure and rlast.
- Bounds outstanding backend reads to the free FIFO space, so returned data is never dropped.

Parameters:
ADDR_WIDTH  26  address width in words (AXI side and backend side)
DATA_WIDTH  32  data width of R channel and backend
FIFO_DEPTH  8   return-data FIFO depth in words; power of two, >= 2
ADDR_INC    1   address increment per beat

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
init_end  input  1  DDR2 initialisation complete; no AR accepted while low
axi_arvalid  input  1  read address valid
axi_arready  output  1  read address ready
axi_araddr  input  ADDR_WIDTH  burst start word address
axi_arlen  input  8  burst length in beats (codebase convention: beats = arlen; 0 means 256)
axi_rvalid  output  1  read data valid
axi_rready  input  1  read data ready
axi_rlast  output  1  final beat of burst
axi_rdata  output  DATA_WIDTH  read data
mem_rd_req  output  1  backend single-word read request
mem_rd_ack  input  1  backend accepts request this cycle
mem_rd_addr  output  ADDR_WIDTH  backend read address
mem_rd_valid  input  1  backend returned word valid (in request order, any latency >= 1)
mem_rd_data  input  DATA_WIDTH  backend returned word
busy  output  1  high while a burst is in progress
rd_err  output  1  sticky: mem_rd_valid received with zero outstanding requests

Behaviour:
- Reset: state IDLE; axi_arready=0, axi_rvalid=0, axi_rlast=0, axi_rdata=0, mem_rd_req=0, mem_rd_addr=0, busy=0, rd_err=0; FIFO flushed; all counters 0. Reset mid-burst abandons the burst without completing R. The backend must be reset together with this block.
- Clocking: all flops on posedge clk. Only axi_rvalid/axi_rdata/axi_rlast/mem_rd_req are combinational from registered state. axi_arready is registered.
- States:
  - IDLE: axi_arready = init_end. On axi_arvalid && axi_arready: latch base = axi_araddr; issue_left = rcv_left = (axi_arlen==0 ? 256 : axi_arlen) (9-bit); next-cycle arready=0, busy=1; go to BURST.
  - BURST: issue and return run concurrently. Go to IDLE the cycle after the R handshake with rcv_left==1. arready rises one cycle later, so there is at most one AR per two cycles.
- Issue side:
  - mem_rd_req = BURST && issue_left!=0 && (fifo_count + outstanding) < FIFO_DEPTH.
  - mem_rd_addr = base + issued*ADDR_INC, modulo 2^ADDR_WIDTH (wrap is silent).
  - A request counts as issued on mem_rd_req && mem_rd_ack: issue_left--, issued++, outstanding++.
  - req and addr hold until ack.
- Return side:
  - mem_rd_valid && outstanding!=0: push mem_rd_data into FIFO, outstanding--.
  - mem_rd_valid && outstanding==0: discard the word and set rd_err (sticky until rst).
  - Issue and return in the same cycle: outstanding unchanged.
- FIFO: first-word-fall-through.
  - axi_rvalid = !empty; axi_rdata = head word.
  - Word pushed at cycle t is visible on R at t+1 at the earliest.
  - Simultaneous push and pop is legal at any fill level, including full (the credit rule prevents overflow) and empty (a pushed word is not popped in the same cycle).
- R channel:
  - A handshake is axi_rvalid && axi_rready: pop, rcv_left--.
  - axi_rlast = axi_rvalid && rcv_left==1.
  - axi_rvalid, axi_rdata and axi_rlast hold stable while axi_rvalid && !axi_rready.
  - axi_rvalid never asserts outside BURST.
- Throughput: with mem_rd_ack tied high, latency L, and rready high, one beat per cycle is sustained when FIFO_DEPTH >= L+1.
- busy = (state==BURST).

Test Plan:
- Basic 8-beat burst: init_end=1, ack=1, latency 3, araddr=0x100, arlen=8, rready=1 -> mem_rd_addr 0x100..0x107 in order; 8 R beats with data equal to the backend model; rlast only on beat 8; arready returns high 2 cycles after the last beat.
- Backpressure: arlen=16, FIFO_DEPTH=8, rready low for 20 cycles -> mem_rd_req stalls with fifo_count+outstanding=8; no data lost; after release 16 beats arrive in order with rdata stable during every stall.
- arlen=0 at araddr=0x3FFFFFE (ADDR_WIDTH=26) -> 256 beats; backend address wraps to 0x0000000 after 0x3FFFFFF; rlast on beat 256.
- Gating: init_end=0 with arvalid high -> arready stays 0; init_end rises -> AR accepted next cycle. Second arvalid during BURST -> not accepted until IDLE.
- Random ack/latency/rready with 200 bursts of random length -> scoreboard matches; rd_err stays 0; outstanding never exceeds FIFO_DEPTH.
- Spurious mem_rd_valid in IDLE -> rd_err=1 and stays 1; rst mid-burst (beat 3 of 8) -> all outputs at reset values next cycle; a new burst then completes correctly.

Source files
------------

// File: rtl/axi_rd_slave.sv
// AXI-style read responder: splits AR bursts into single-word backend reads and
// streams the returned words on R through a small first-word-fall-through FIFO.
module axi_rd_slave #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_end,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic                  axi_rlast,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  rd_err
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LEN_W = 9;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic                  arready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      issue_left_q, rcv_left_q;
    logic [CNT_W-1:0]      outstanding_q, fifo_count_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  rd_err_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                  ar_hs, issue, push, discard, pop;
    logic [CNT_W:0]        credit_used;
    logic [LEN_W-1:0]      burst_len;

    // Next state, credit-limited issue, FIFO head presentation
    always_comb begin
        state_d     = state_q;
        ar_hs       = axi_arvalid && arready_q;
        burst_len   = (axi_arlen == 8'd0) ? LEN_W'(256) : LEN_W'(axi_arlen);
        credit_used = (CNT_W+1)'(fifo_count_q) + (CNT_W+1)'(outstanding_q);
        mem_rd_req  = (state_q == BURST) && (issue_left_q != '0)
                      && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        issue       = mem_rd_req && mem_rd_ack;
        push        = mem_rd_valid && (outstanding_q != '0);
        discard     = mem_rd_valid && (outstanding_q == '0);
        axi_rvalid  = (state_q == BURST) && (fifo_count_q != '0);
        axi_rdata   = axi_rvalid ? fifo_mem[rd_ptr_q] : '0;
        axi_rlast   = axi_rvalid && (rcv_left_q == LEN_W'(1));
        pop         = axi_rvalid && axi_rready;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (pop && axi_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            arready_q     <= 1'b0;
            addr_q        <= '0;
            issue_left_q  <= '0;
            rcv_left_q    <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // Held low for the first IDLE cycle after a burst: one AR per two cycles
            arready_q <= (state_q == IDLE) && (state_d == IDLE) && init_end;
            if (ar_hs) begin
                addr_q       <= axi_araddr;
                issue_left_q <= burst_len;
                rcv_left_q   <= burst_len;
            end else begin
                if (issue) begin
                    addr_q       <= addr_q + ADDR_WIDTH'(ADDR_INC);
                    issue_left_q <= issue_left_q - LEN_W'(1);
                end
                if (pop) rcv_left_q <= rcv_left_q - LEN_W'(1);
            end
            case ({issue, push})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (discard) rd_err_q <= 1'b1;
        end
    end

    // Storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rd_data;
    end

    assign axi_arready = arready_q;
    assign mem_rd_addr = addr_q;
    assign busy        = (state_q == BURST);
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: in-order backend model with configurable
// latency/ack, R consumer with configurable backpressure, single-threaded per cycle.
module tb_axi_rd_slave;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, init_end;
    logic          axi_arvalid, axi_arready;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic          axi_rvalid, axi_rready, axi_rlast;
    logic [DW-1:0] axi_rdata;
    logic          mem_rd_req, mem_rd_ack;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          busy, rd_err;

    axi_rd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_INC(1)) dut (
        .clk(clk), .rst(rst), .init_end(init_end),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .busy(busy), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } be_t;

    be_t           be_q[$];
    int            n_cmp = 0, n_err = 0;
    int            cyc = 0;
    logic [AW-1:0] cur_base = '0;
    int            cur_len = 0;
    int            iss_cnt = 0, iss_total = 0, ret_total = 0, pop_total = 0, last_total = 0;
    int            rx_beat = 0, max_inflight = 0;
    int            lat_min = 1, lat_max = 1, rr_mode = 0;
    bit            ack_rand = 0, spur = 0;
    logic [AW-1:0] last_iss_addr = '0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        return {a[15:0], 6'b0, a[25:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Backend: in-order returns, per-request latency, optional random ack
    task automatic be_step();
        be_t           e;
        logic [AW-1:0] exp_a;
        if (rst) begin
            be_q.delete();
            mem_rd_valid = 1'b0;
            mem_rd_ack   = 1'b0;
            iss_cnt      = 0;
            return;
        end
        if (!busy) iss_cnt = 0;
        mem_rd_valid = 1'b0;
        if (spur) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hBAD0_BAD0;
            spur         = 0;
        end else if (be_q.size() != 0 && be_q[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = be_q[0].data;
            void'(be_q.pop_front());
            ret_total++;
        end
        mem_rd_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_rd_req && mem_rd_ack) begin
            exp_a = cur_base + AW'(iss_cnt);
            check("mem_addr", mem_rd_addr, exp_a);
            e.data = fdata(mem_rd_addr);
            e.due  = cyc + int'($urandom_range(lat_min, lat_max));
            be_q.push_back(e);
            last_iss_addr = mem_rd_addr;
            iss_cnt++;
            iss_total++;
        end
    endtask

    // R consumer: data/rlast against address model, stability under stall
    task automatic rx_step();
        logic [AW-1:0] exp_a;
        if (rst) begin
            rx_beat    = 0;
            prev_stall = 0;
            axi_rready = 1'b0;
            return;
        end
        if (!busy) rx_beat = 0;
        check("rvalid_idle", axi_rvalid & ~busy, 1'b0);
        if (prev_stall) begin
            check("stall_valid", axi_rvalid, 1'b1);
            check("stall_data", axi_rdata, prev_data);
            check("stall_last", axi_rlast, prev_last);
        end
        axi_rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        if (axi_rvalid) begin
            exp_a = cur_base + AW'(rx_beat);
            check("rdata", axi_rdata, fdata(exp_a));
            check("rlast", axi_rlast, (rx_beat + 1 == cur_len));
            if (axi_rready) begin
                rx_beat++;
                pop_total++;
                if (axi_rlast) last_total++;
            end
        end
        prev_stall = axi_rvalid && !axi_rready;
        prev_data  = axi_rdata;
        prev_last  = axi_rlast;
    endtask

    task automatic tick();
        int infl;
        @(negedge clk);
        cyc++;
        be_step();
        rx_step();
        if (rst) ret_total = pop_total;
        infl = be_q.size() + ret_total - pop_total;
        if (infl > max_inflight) max_inflight = infl;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] l);
        int n = 0;
        cur_base    = a;
        cur_len     = (l == 8'd0) ? 256 : int'(l);
        axi_araddr  = a;
        axi_arlen   = l;
        axi_arvalid = 1'b1;
        while (!axi_arready && n < 200) begin
            tick();
            n++;
        end
        check("ar_accept", axi_arready, 1'b1);
        tick();
        axi_arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        check("burst_done", busy, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_arready"}, axi_arready, 1'b0);
        check({tag, "_rvalid"}, axi_rvalid, 1'b0);
        check({tag, "_rlast"}, axi_rlast, 1'b0);
        check({tag, "_rdata"}, axi_rdata, '0);
        check({tag, "_req"}, mem_rd_req, 1'b0);
        check({tag, "_addr"}, mem_rd_addr, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rd_err"}, rd_err, 1'b0);
    endtask

    initial begin
        int p0, l0, i0, n, beats_exp;
        rst = 1'b1; init_end = 1'b0; axi_arvalid = 1'b0; axi_araddr = '0; axi_arlen = '0;
        axi_rready = 1'b0; mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        init_end = 1'b1;

        // Basic 8-beat burst, latency 3
        lat_min = 3; lat_max = 3; ack_rand = 0; rr_mode = 0;
        p0 = pop_total; l0 = last_total; i0 = iss_total;
        send_ar(26'h100, 8'd8);
        wait_done();
        check("t1_beats", pop_total - p0, 8);
        check("t1_rlast_cnt", last_total - l0, 1);
        check("t1_issues", iss_total - i0, 8);
        check("t1_last_addr", last_iss_addr, 26'h107);
        check("t1_arready_lo", axi_arready, 1'b0);
        tick();
        check("t1_arready_hi", axi_arready, 1'b1);

        // Backpressure: credits exhaust at FIFO_DEPTH
        rr_mode = 2; p0 = pop_total;
        send_ar(26'h2000, 8'd16);
        repeat (20) tick();
        check("t2_req_stalled", mem_rd_req, 1'b0);
        check("t2_inflight", be_q.size() + ret_total - pop_total, DEPTH);
        check("t2_no_pop", pop_total - p0, 0);
        rr_mode = 1;
        wait_done();
        check("t2_beats", pop_total - p0, 16);

        // arlen=0 -> 256 beats, address wraps
        rr_mode = 0; lat_min = 2; lat_max = 2; p0 = pop_total; l0 = last_total;
        send_ar(26'h3FF_FFFE, 8'd0);
        wait_done();
        check("t3_beats", pop_total - p0, 256);
        check("t3_rlast_cnt", last_total - l0, 1);
        check("t3_last_addr", last_iss_addr, 26'h0FD);

        // init_end gating and AR blocked during BURST
        p0 = pop_total;
        init_end = 1'b0;
        tick();
        check("t4_arready_drop", axi_arready, 1'b0);
        cur_base = 26'h40; cur_len = 4;
        axi_araddr = 26'h40; axi_arlen = 8'd4; axi_arvalid = 1'b1;
        repeat (5) begin
            tick();
            check("t4_gated", axi_arready, 1'b0);
            check("t4_idle", busy, 1'b0);
        end
        init_end = 1'b1;
        tick();
        check("t4_arready_rise", axi_arready, 1'b1);
        tick();
        check("t4_busy", busy, 1'b1);
        n = 0;
        while (busy && n < 200) begin
            check("t4_no_2nd_ar", axi_arready, 1'b0);
            tick();
            n++;
        end
        check("t4_arready_idle", axi_arready, 1'b0);
        tick();
        check("t4_2nd_accept", axi_arready, 1'b1);
        tick();
        axi_arvalid = 1'b0;
        check("t4_2nd_busy", busy, 1'b1);
        wait_done();
        check("t4_beats", pop_total - p0, 8);

        // Random ack, latency, backpressure
        ack_rand = 1; lat_min = 1; lat_max = 6; rr_mode = 1;
        p0 = pop_total; beats_exp = 0;
        for (int b = 0; b < 200; b++) begin
            n = int'($urandom_range(1, 32));
            beats_exp += n;
            send_ar(AW'($urandom), 8'(n));
            wait_done();
        end
        check("t5_beats", pop_total - p0, beats_exp);
        check("t5_rd_err", rd_err, 1'b0);
        check("t5_inflight_bound", max_inflight <= int'(DEPTH), 1'b1);

        // Spurious return in IDLE, then reset mid-burst
        ack_rand = 0; lat_min = 2; lat_max = 2; rr_mode = 0;
        tick();
        spur = 1;
        tick();
        tick();
        check("t6_rd_err_set", rd_err, 1'b1);
        repeat (5) tick();
        check("t6_rd_err_sticky", rd_err, 1'b1);
        check("t6_idle_rvalid", axi_rvalid, 1'b0);
        p0 = pop_total;
        send_ar(26'h555, 8'd8);
        n = 0;
        while (pop_total - p0 < 2 && n < 100) begin
            tick();
            n++;
        end
        check("t6_mid_burst", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk_reset("t6_rst");
        rst = 1'b0;
        p0 = pop_total; l0 = last_total;
        send_ar(26'h7F0, 8'd8);
        wait_done();
        check("t6_beats", pop_total - p0, 8);
        check("t6_rlast_cnt", last_total - l0, 1);
        check("t6_rd_err_clear", rd_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
